// File: rtl/layer_priority_ctrl_pkg.sv
// Shared types for the layer priority controller: slot entry, FSM states, defaults.
// Package objects_pkg; the layer_priority_ctrl top must be built with NUM_LAYERS equal to the value here.
package objects_pkg;

  localparam int          NUM_LAYERS = 8;
  localparam int          LAYER_W    = $clog2(NUM_LAYERS);
  localparam logic [7:0]  BG_COLOR   = 8'h00;

  typedef logic [LAYER_W-1:0] layer_idx_t;

  typedef struct packed {
    layer_idx_t layer;
    logic       enable;
    logic       blink;
  } slot_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_e;

  function automatic slot_entry_t identity_entry(input int slot);
    slot_entry_t e;
    e.layer  = layer_idx_t'(slot);
    e.enable = 1'b1;
    e.blink  = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/layer_priority_ctrl_if.sv
// Configuration bus of the layer priority controller: slot writes and commit requests.
interface layer_priority_ctrl_if;
  import objects_pkg::*;

  logic       cfgValid;
  logic       cfgReady;
  layer_idx_t cfgSlot;
  layer_idx_t cfgLayer;
  logic       cfgEnable;
  logic       cfgBlink;
  logic       cfgCommit;

  modport master (
    output cfgValid, cfgSlot, cfgLayer, cfgEnable, cfgBlink, cfgCommit,
    input  cfgReady
  );

  modport slave (
    input  cfgValid, cfgSlot, cfgLayer, cfgEnable, cfgBlink, cfgCommit,
    output cfgReady
  );

endinterface

// File: rtl/layer_priority_ctrl_pick.sv
// Combinational winner search: lowest slot that is enabled, requested and not blanked.
module layer_priority_pick
  import objects_pkg::*;
(
  input  slot_entry_t [NUM_LAYERS-1:0] slots_i,
  input  logic [NUM_LAYERS-1:0]        layer_dr_i,
  input  logic                         blank_phase_i,
  output logic                         found_o,
  output layer_idx_t                   layer_o
);

  logic [NUM_LAYERS-1:0] slot_hit;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
    assign slot_hit[gi] = slots_i[gi].enable
                       && layer_dr_i[slots_i[gi].layer]
                       && !(blank_phase_i && slots_i[gi].blink);
  end

  // Scan from the top so the lowest hitting slot overwrites last and wins.
  always_comb begin
    found_o = 1'b0;
    layer_o = '0;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if (slot_hit[s]) begin
        found_o = 1'b1;
        layer_o = slots_i[s].layer;
      end
    end
  end

endmodule

// File: rtl/layer_priority_ctrl.sv
// Layer priority mux with a shadow/active slot table swapped on frame boundaries.
// Optional per-slot blinking is compiled in with `define LAYER_BLINK_EN.
module layer_priority_ctrl #(
  parameter int         NUM_LAYERS   = objects_pkg::NUM_LAYERS,
  parameter logic [7:0] BG_COLOR     = objects_pkg::BG_COLOR,
  parameter int         BLINK_FRAMES = 16
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic [NUM_LAYERS-1:0]        layerDR,
  input  logic [NUM_LAYERS-1:0][7:0]   layerRGB,
  layer_priority_ctrl_if.slave         cfg,
  output logic [7:0]                   RGBOut,
  output objects_pkg::layer_idx_t      winLayer,
  output logic                         anyDR,
  output logic                         applyPending
);

  objects_pkg::state_e                          state_q, state_d;
  objects_pkg::slot_entry_t [NUM_LAYERS-1:0]    shadow_q, shadow_d;
  objects_pkg::slot_entry_t [NUM_LAYERS-1:0]    active_q, active_d;
  logic                                         cfg_wr;
  logic                                         blink_bit;
  logic                                         blink_phase;
  logic                                         pick_found;
  objects_pkg::layer_idx_t                      pick_layer;
  logic [7:0]                                   rgb_q;
  objects_pkg::layer_idx_t                      win_q;
  logic                                         any_q;

  assign cfg.cfgReady = (state_q == objects_pkg::IDLE);
  assign cfg_wr       = cfg.cfgValid && cfg.cfgReady;
  assign applyPending = (state_q == objects_pkg::PENDING);

`ifdef LAYER_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (startOfFrame) begin
      if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_bit   = cfg.cfgBlink;
  assign blink_phase = blink_phase_q;
`else
  logic unused_blink;
  assign unused_blink = cfg.cfgBlink ^ (BLINK_FRAMES == 0);
  assign blink_bit    = 1'b0;
  assign blink_phase  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    if (cfg_wr) begin
      shadow_d[cfg.cfgSlot] = '{layer: cfg.cfgLayer, enable: cfg.cfgEnable, blink: blink_bit};
    end
    case (state_q)
      objects_pkg::IDLE:    if (cfg.cfgCommit) state_d = objects_pkg::PENDING;
      objects_pkg::PENDING: if (startOfFrame)  state_d = objects_pkg::APPLY;
      objects_pkg::APPLY:   state_d = objects_pkg::IDLE;
      default:              state_d = objects_pkg::IDLE;
    endcase
  end

  // The pick sees the new table during APPLY itself, so only the frame's first pixel uses the old one.
  assign active_d = (state_q == objects_pkg::APPLY) ? shadow_q : active_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= objects_pkg::IDLE;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= objects_pkg::identity_entry(i);
        active_q[i] <= objects_pkg::identity_entry(i);
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  layer_priority_pick u_pick (
    .slots_i       (active_d),
    .layer_dr_i    (layerDR),
    .blank_phase_i (blink_phase),
    .found_o       (pick_found),
    .layer_o       (pick_layer)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q <= 8'h00;
      win_q <= '0;
      any_q <= 1'b0;
    end else if (pick_found) begin
      rgb_q <= layerRGB[pick_layer];
      win_q <= pick_layer;
      any_q <= 1'b1;
    end else begin
      rgb_q <= BG_COLOR;
      win_q <= '0;
      any_q <= 1'b0;
    end
  end

  assign RGBOut   = rgb_q;
  assign winLayer = win_q;
  assign anyDR    = any_q;

endmodule

// File: doc/layer_priority_ctrl.md
LAYER_PRIORITY_CTRL -- requirements
Module: layer_priority_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 8, meaning the number of drawing layers.
REQ-002 The block SHALL have parameter BG_COLOR, default 8'h00, meaning the output colour when no enabled layer draws.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 16, meaning the number of frames per blink half-period.
REQ-004 The block SHALL have port clk, input, 1, the single clock.
REQ-005 The block SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port startOfFrame, input, 1, a one-cycle pulse at the first pixel of each frame.
REQ-007 The block SHALL have port layerDR, input, NUM_LAYERS, the per-layer drawing request.
REQ-008 The block SHALL have port layerRGB, input, NUM_LAYERS x 8, the per-layer colour.
REQ-009 The block SHALL have port cfgValid, input, 1, a slot-write request.
REQ-010 The block SHALL have port cfgReady, output, 1, meaning a slot write can be accepted.
REQ-011 The block SHALL have port cfgSlot, input, log2(NUM_LAYERS), the priority slot to write (0 = highest).
REQ-012 The block SHALL have port cfgLayer, input, log2(NUM_LAYERS), the layer index assigned to the slot.
REQ-013 The block SHALL have port cfgEnable, input, 1, the slot enable bit.
REQ-014 The block SHALL have port cfgBlink, input, 1, the slot blink bit.
REQ-015 The block SHALL have port cfgCommit, input, 1, requesting that the shadow table be applied.
REQ-016 The block SHALL have port RGBOut, output, 8, the selected pixel colour.
REQ-017 The block SHALL have port winLayer, output, log2(NUM_LAYERS), the winning layer index (0 when none wins).
REQ-018 The block SHALL have port anyDR, output, 1, high when some enabled layer won.
REQ-019 The block SHALL have port applyPending, output, 1, high while a commit is waiting for startOfFrame.

Function
REQ-020 The block SHALL hold a shadow table and an active table, each NUM_LAYERS entries of {layer, enable, blink}.
REQ-021 A write SHALL be accepted on a cycle with cfgValid&&cfgReady, updating only shadow[cfgSlot].
REQ-022 The FSM SHALL have states IDLE, PENDING and APPLY; cfgReady SHALL be 1 only in IDLE.
REQ-023 IDLE SHALL go to PENDING on cfgCommit; a write and a commit in the same cycle SHALL both take effect, write first.
REQ-024 PENDING SHALL go to APPLY on the first startOfFrame seen strictly after entering PENDING; a startOfFrame in the commit cycle SHALL NOT apply.
REQ-025 APPLY SHALL copy shadow to active in one cycle and return to IDLE.
REQ-026 The copy SHALL be visible on RGBOut no later than the second pixel of the frame; a frame SHALL never mix old and new tables beyond that pixel.
REQ-027 cfgCommit in PENDING or APPLY SHALL be ignored.
REQ-028 The winner SHALL be the lowest slot s with active[s].enable, layerDR[active[s].layer] and not blanked.
REQ-029 A registered output with 1-cycle latency SHALL drive RGBOut=layerRGB[winner], winLayer=winner and anyDR=1; with no winner it SHALL drive BG_COLOR, 0 and 0.
REQ-030 Duplicate layers in the table SHALL be legal (the higher slot wins); a layer absent from the table SHALL never be drawn.

Reset
REQ-031 Asserting resetN low SHALL asynchronously set RGBOut=0, winLayer=0, anyDR=0, applyPending=0, state=IDLE and cfgReady=1.
REQ-032 Reset SHALL set both tables to the identity mapping (slot i = layer i) with enable=1 and blink=0, and clear the blink counter and phase.
REQ-033 Reset during PENDING SHALL discard the pending commit.

Configuration
REQ-034 With LAYER_BLINK_EN defined, a frame counter SHALL count startOfFrame pulses and toggle the blink phase every BLINK_FRAMES frames, wrapping to 0.
REQ-035 With LAYER_BLINK_EN defined and the phase at 1, slots with blink=1 SHALL be blanked.
REQ-036 Without LAYER_BLINK_EN, cfgBlink SHALL be ignored, the counter SHALL be absent, and no slot SHALL be blanked.

Structure
REQ-037 Package objects_pkg SHALL hold NUM_LAYERS, the layer-index typedef, the slot-entry struct, the FSM state enum and BG_COLOR.
REQ-038 The winner search SHALL be a combinational sub-module, layer_priority_pick.

Verification
REQ-039 Bench scenario (reset): after reset, layerDR=8'b0000_0110 -> RGBOut=layerRGB[1], winLayer=1, one cycle later.
REQ-040 Bench scenario (reorder): write slot0=layer2 and commit; mid-frame output stays layer1 until startOfFrame, then becomes layer2 from the next pixel on.
REQ-041 Bench scenario (handshake): cfgValid during PENDING -> cfgReady=0 and the shadow is unchanged; after APPLY, cfgReady=1.
REQ-042 Bench scenario (boundary): cfgCommit on the same cycle as startOfFrame -> applied at the following startOfFrame, not this one.
REQ-043 Bench scenario (blink, LAYER_BLINK_EN, BLINK_FRAMES=2): a blink layer is drawn on frames 0-1, blanked on frames 2-3 (lower slot shown) and drawn again on frame 4.
REQ-044 Bench scenario (disable/reset): with all slots disabled, RGBOut=BG_COLOR and anyDR=0; a resetN pulse during PENDING leaves the identity table active and applyPending=0.
